// File: rtl/pipeline_interlock.sv
// Load-use interlock and forwarding-select generator for an in-order pipeline.
// Tracks DEPTH post-decode stages (entry 0 = EX), stalls the decoded instruction
// when its youngest producer is a load too close to forward, and registers the
// EX-stage operand source selects for each accepted issue.
module pipeline_interlock #(
  parameter int unsigned NUM_REGISTERS_LOG2 = 5,
  parameter int unsigned DEPTH              = 3,
  parameter int unsigned LOAD_DIST          = 2,
  parameter int unsigned FLUSH_COUNT        = 2,
  parameter int unsigned FORWARD_BITS       = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic [NUM_REGISTERS_LOG2-1:0] issue_rd,
  input  logic                          issue_reg_write,
  input  logic                          issue_is_load,
  input  logic [NUM_REGISTERS_LOG2-1:0] src_rs,
  input  logic [NUM_REGISTERS_LOG2-1:0] src_rt,
  input  logic                          flush,
  output logic                          stall,
  output logic [FORWARD_BITS-1:0]       forward_a,
  output logic [FORWARD_BITS-1:0]       forward_b,
  output logic [15:0]                   stall_count
);

  localparam int unsigned RW = NUM_REGISTERS_LOG2;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          is_load;
  } entry_t;

  entry_t [DEPTH-1:0]      pipe_q, pipe_d;
  logic [FORWARD_BITS-1:0] forward_a_q, forward_a_d;
  logic [FORWARD_BITS-1:0] forward_b_q, forward_b_d;
  logic [15:0]             stall_count_q, stall_count_d;

  logic                    hit_a, hit_b;
  logic                    near_a, near_b;
  logic [FORWARD_BITS-1:0] dist_a, dist_b;
  logic                    accept;

  // Youngest-producer search per source; scanning old-to-young lets the youngest overwrite.
  always_comb begin
    hit_a  = 1'b0;
    hit_b  = 1'b0;
    near_a = 1'b0;
    near_b = 1'b0;
    dist_a = '0;
    dist_b = '0;
    for (int j = int'(DEPTH) - 2; j >= 0; j--) begin
      if (pipe_q[j].valid && pipe_q[j].reg_write && (src_rs != '0) && (pipe_q[j].rd == src_rs)) begin
        hit_a  = 1'b1;
        dist_a = FORWARD_BITS'(j + 1);
        near_a = pipe_q[j].is_load && ((j + 1) < int'(LOAD_DIST));
      end
      if (pipe_q[j].valid && pipe_q[j].reg_write && (src_rt != '0) && (pipe_q[j].rd == src_rt)) begin
        hit_b  = 1'b1;
        dist_b = FORWARD_BITS'(j + 1);
        near_b = pipe_q[j].is_load && ((j + 1) < int'(LOAD_DIST));
      end
    end
  end

  // Stall and next-state: flush squashes young entries and the issue, stall inserts a bubble.
  always_comb begin
    stall         = issue_valid && !flush && (near_a || near_b);
    accept        = issue_valid && !stall && !flush;
    pipe_d        = '0;
    forward_a_d   = '0;
    forward_b_d   = '0;
    stall_count_d = stall_count_q;

    if (accept) begin
      pipe_d[0].valid     = 1'b1;
      pipe_d[0].rd        = issue_rd;
      pipe_d[0].reg_write = issue_reg_write;
      pipe_d[0].is_load   = issue_is_load;
      forward_a_d         = hit_a ? dist_a : '0;
      forward_b_d         = hit_b ? dist_b : '0;
    end

    for (int j = 1; j < int'(DEPTH); j++) begin
      pipe_d[j] = pipe_q[j-1];
      if (flush && ((j - 1) < int'(FLUSH_COUNT))) begin
        pipe_d[j].valid = 1'b0;
      end
    end

    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q        <= '0;
      forward_a_q   <= '0;
      forward_b_q   <= '0;
      stall_count_q <= '0;
    end else begin
      pipe_q        <= pipe_d;
      forward_a_q   <= forward_a_d;
      forward_b_q   <= forward_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign forward_a   = forward_a_q;
  assign forward_b   = forward_b_q;
  assign stall_count = stall_count_q;

endmodule
